// File: rtl/count_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer_if
//  Description : Control/status bundle between key inputs, count_sequencer
//                and the seven-segment decoder.
//  Revision    : 1.0  initial release
// ============================================================================
interface count_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             pause;
    logic [1:0]       speed;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] target;
`ifdef COUNT_DOWN_EN
    logic             dir;
`endif
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             busy;
    logic             paused;
    logic             done;

    modport master (
`ifdef COUNT_DOWN_EN
        output dir,
`endif
        output start, stop, pause, speed, load_val, target,
        input  count, tick, busy, paused, done
    );

    modport slave (
`ifdef COUNT_DOWN_EN
        input  dir,
`endif
        input  start, stop, pause, speed, load_val, target,
        output count, tick, busy, paused, done
    );
endinterface
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer
//  Description : Sequences the display counter: load, advance at a prescaled
//                rate until target, with pause/stop/done. Optional down
//                counting is enabled by defining COUNT_DOWN_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module count_sequencer #(
    parameter int          WIDTH = 4,
    parameter int          DIVW  = 26,
    parameter int unsigned DIV0  = 1,
    parameter int unsigned DIV1  = 5,
    parameter int unsigned DIV2  = 10,
    parameter int unsigned DIV3  = 20
) (
    input  logic            clock,
    input  logic            reset,
    count_sequencer_if.slave bus
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nx;
    logic [DIVW-1:0]  r_presc;
    logic [DIVW-1:0]  w_presc_nx;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nx;
    logic [WIDTH-1:0] w_count_step;
    logic             r_tick;
    logic             w_tick_nx;
    logic             r_done;
    logic             w_done_nx;
    logic             r_busy;
    logic             r_paused;
    logic [1:0]       r_speed;
    logic [WIDTH-1:0] r_target;
    logic             w_active;
    logic             w_accept;
    logic             w_run_en;
    logic             w_advance;
    logic             w_hit;

    function automatic logic [DIVW-1:0] f_reload(input logic [1:0] sel);
        case (sel)
            2'b00:   f_reload = DIVW'(DIV0 - 1);
            2'b01:   f_reload = DIVW'(DIV1 - 1);
            2'b10:   f_reload = DIVW'(DIV2 - 1);
            default: f_reload = DIVW'(DIV3 - 1);
        endcase
    endfunction

`ifdef COUNT_DOWN_EN
    logic r_dir;
    assign w_count_step = r_dir ? (r_count - WIDTH'(1)) : (r_count + WIDTH'(1));
`else
    assign w_count_step = r_count + WIDTH'(1);
`endif

    // Pause acts as a per-cycle enable, so released cycles count immediately.
    assign w_active  = (r_state == c_st_run) || (r_state == c_st_pause);
    assign w_accept  = ((r_state == c_st_idle) || (r_state == c_st_done)) &&
                       bus.start && !bus.stop;
    assign w_run_en  = w_active && !bus.stop && !bus.pause;
    assign w_advance = w_run_en && (r_presc == '0);
    assign w_hit     = w_advance && (w_count_step == r_target);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept) w_state_nx = c_st_run;
            end
            c_st_run, c_st_pause: begin
                if (bus.stop)       w_state_nx = c_st_idle;
                else if (bus.pause) w_state_nx = c_st_pause;
                else if (w_hit)     w_state_nx = c_st_done;
                else                w_state_nx = c_st_run;
            end
            c_st_done: begin
                w_state_nx = w_accept ? c_st_run : c_st_idle;
            end
            default: w_state_nx = c_st_idle;
        endcase
    end

    always_comb begin
        w_presc_nx = r_presc;
        w_count_nx = r_count;
        w_tick_nx  = 1'b0;
        w_done_nx  = 1'b0;
        if (w_accept) begin
            w_count_nx = bus.load_val;
            w_presc_nx = f_reload(bus.speed);
        end else if (w_run_en) begin
            if (w_advance) begin
                w_presc_nx = f_reload(r_speed);
                w_count_nx = w_hit ? r_target : w_count_step;
                w_tick_nx  = 1'b1;
                w_done_nx  = w_hit;
            end else begin
                w_presc_nx = r_presc - DIVW'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_presc  <= '0;
            r_count  <= '0;
            r_tick   <= 1'b0;
            r_done   <= 1'b0;
            r_busy   <= 1'b0;
            r_paused <= 1'b0;
            r_speed  <= 2'b00;
            r_target <= '0;
`ifdef COUNT_DOWN_EN
            r_dir    <= 1'b0;
`endif
        end else begin
            r_presc  <= w_presc_nx;
            r_count  <= w_count_nx;
            r_tick   <= w_tick_nx;
            r_done   <= w_done_nx;
            r_busy   <= (w_state_nx == c_st_run) || (w_state_nx == c_st_pause);
            r_paused <= (w_state_nx == c_st_pause);
            if (w_accept) begin
                r_speed  <= bus.speed;
                r_target <= bus.target;
`ifdef COUNT_DOWN_EN
                r_dir    <= bus.dir;
`endif
            end
        end
    end

    assign bus.count  = r_count;
    assign bus.tick   = r_tick;
    assign bus.busy   = r_busy;
    assign bus.paused = r_paused;
    assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sequencer
//  Description : Directed self-checking bench for count_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_count_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   vectors = 0;
    int   errs    = 0;

    count_sequencer_if #(.WIDTH(4)) bus ();

    count_sequencer #(.WIDTH(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [1:0] spd, input logic [3:0] ld, input logic [3:0] tg);
        bus.speed    = spd;
        bus.load_val = ld;
        bus.target   = tg;
        bus.start    = 1'b1;
        step();
        bus.start    = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.pause = 0;
        bus.speed = 0; bus.load_val = 0; bus.target = 0;
`ifdef COUNT_DOWN_EN
        bus.dir = 0;
`endif
        step(); step();
        chk("rst_count", bus.count, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_paused", bus.paused, 0);
        reset = 0;
        step();

        // speed 00, 3 -> 6
        go(2'b00, 4'd3, 4'd6);
        chk("t2_load", bus.count, 3);
        chk("t2_busy", bus.busy, 1);
        chk("t2_tick0", bus.tick, 0);
        step(); chk("t2_c4", bus.count, 4); chk("t2_tk1", bus.tick, 1); chk("t2_dn1", bus.done, 0);
        step(); chk("t2_c5", bus.count, 5); chk("t2_tk2", bus.tick, 1);
        step(); chk("t2_c6", bus.count, 6); chk("t2_tk3", bus.tick, 1); chk("t2_done", bus.done, 1);
        chk("t2_busy_done", bus.busy, 0);
        step(); chk("t2_done_off", bus.done, 0); chk("t2_idle_busy", bus.busy, 0);
        chk("t2_hold", bus.count, 6); chk("t2_tick_off", bus.tick, 0);

        // speed 01, 14 -> 1 with wrap
        go(2'b01, 4'd14, 4'd1);
        chk("t3_load", bus.count, 14);
        for (int k = 1; k <= 15; k++) begin
            step();
            chk("t3_tick", bus.tick, (k % 5 == 0) ? 1 : 0);
            chk("t3_done", bus.done, (k == 15) ? 1 : 0);
            if (k == 5)  chk("t3_c15", bus.count, 15);
            if (k == 10) chk("t3_c0", bus.count, 0);
            if (k == 14) chk("t3_c0b", bus.count, 0);
        end
        chk("t3_c1", bus.count, 1);
        step(); chk("t3_idle", bus.busy, 0);

        // speed 10, pause 23 cycles mid-interval
        go(2'b10, 4'd0, 4'd15);
        for (int k = 1; k <= 13; k++) begin
            step();
            if (k == 9)  chk("t4_pre_tick", bus.tick, 0);
            if (k == 10) begin chk("t4_tick1", bus.tick, 1); chk("t4_c1", bus.count, 1); end
        end
        bus.pause = 1'b1;
        for (int k = 14; k <= 36; k++) begin
            step();
            chk("t4_paused", bus.paused, 1);
            chk("t4_busy", bus.busy, 1);
            chk("t4_frozen", bus.count, 1);
            chk("t4_notick", bus.tick, 0);
        end
        bus.pause = 1'b0;
        for (int k = 37; k <= 43; k++) begin
            step();
            if (k == 37) chk("t4_resumed", bus.paused, 0);
            if (k == 42) chk("t4_early", bus.tick, 0);
        end
        chk("t4_tick2", bus.tick, 1);
        chk("t4_c2", bus.count, 2);

        // stop aborts, count holds
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t5_stop_busy", bus.busy, 0);
        chk("t5_stop_count", bus.count, 2);

        // start while busy ignored; stop coincides with tick at count 9
        go(2'b01, 4'd8, 4'd3);
        step(); step();
        bus.start = 1'b1; bus.speed = 2'b00; bus.load_val = 4'd0;
        step();
        bus.start = 1'b0;
        chk("t5_ign_count", bus.count, 8);
        chk("t5_ign_busy", bus.busy, 1);
        step(); chk("t5_ign_tick", bus.tick, 0);
        step(); chk("t5_c9", bus.count, 9); chk("t5_tick", bus.tick, 1);
        for (int k = 6; k <= 9; k++) step();
        bus.stop = 1'b1;
        step();
        bus.stop = 1'b0;
        chk("t5_sc_count", bus.count, 9);
        chk("t5_sc_tick", bus.tick, 0);
        chk("t5_sc_done", bus.done, 0);
        chk("t5_sc_busy", bus.busy, 0);
        step(); chk("t5_sc_hold", bus.count, 9);

        // load == target: full wrap
        go(2'b00, 4'd5, 4'd5);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t6_tick", bus.tick, 1);
            chk("t6_done", bus.done, (k == 16) ? 1 : 0);
            if (k == 11) chk("t6_wrap", bus.count, 0);
        end
        chk("t6_c5", bus.count, 5);
        step(); chk("t6_idle", bus.busy, 0);

`ifdef COUNT_DOWN_EN
        bus.dir = 1'b1;
        go(2'b00, 4'd2, 4'd14);
        bus.dir = 1'b0;
        step(); chk("dn_c1", bus.count, 1);
        step(); chk("dn_c0", bus.count, 0);
        step(); chk("dn_c15", bus.count, 15); chk("dn_nd", bus.done, 0);
        step(); chk("dn_c14", bus.count, 14); chk("dn_done", bus.done, 1);
        step();
`endif

        // asynchronous reset mid-run
        go(2'b00, 4'd0, 4'd15);
        for (int k = 1; k <= 7; k++) step();
        chk("t1_c7", bus.count, 7);
        #2 reset = 1'b1;
        #1;
        chk("t1_count", bus.count, 0);
        chk("t1_busy", bus.busy, 0);
        chk("t1_done", bus.done, 0);
        chk("t1_tick", bus.tick, 0);
        step();
        reset = 1'b0;
        step();
        chk("t1_stay", bus.count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
`default_nettype wire
